// File: rtl/pcore_types_pkg.sv
// Shared pipeline types: writeback result select, load formats and writeback FSM states.
package pcore_types_pkg;

  localparam int XLEN      = 32;
  localparam int RF_AWIDTH = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_CSR  = 2'd2,
    WB_LOAD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd4,
    LD_HU = 3'd5
  } ld_ops_e;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_LD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half of the aligned word
// and sign- or zero-extends it to XLEN.
module load_formatter
  import pcore_types_pkg::*;
#(
  parameter int XLEN = pcore_types_pkg::XLEN
) (
  input  logic [2:0]      ld_ops,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw_data,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword offset bit 0 is ignored: the LSU only issues aligned halves.
  always_comb begin
    byte_sel = raw_data[{offset, 3'b000} +: 8];
    half_sel = raw_data[{offset[1], 4'b0000} +: 16];
    case (ld_ops)
      LD_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_data = raw_data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: owns the single register-file write port, selects the result source,
// waits for multi-cycle load data and stalls execute while a load is outstanding.
module writeback_unit
  import pcore_types_pkg::*;
#(
  parameter int XLEN      = pcore_types_pkg::XLEN,
  parameter int RF_AWIDTH = pcore_types_pkg::RF_AWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exe2wb_valid_i,
  input  logic                 exe2wb_rd_wr_req_i,
  input  logic [RF_AWIDTH-1:0] exe2wb_rd_addr_i,
  input  logic [1:0]           exe2wb_wb_sel_i,
  input  logic [XLEN-1:0]      exe2wb_alu_result_i,
  input  logic [XLEN-1:0]      exe2wb_pc_i,
  input  logic [XLEN-1:0]      exe2wb_csr_rdata_i,
  input  logic [2:0]           exe2wb_ld_ops_i,
  input  logic                 exe2wb_flush_i,
  input  logic                 lsu2wb_ld_valid_i,
  input  logic [XLEN-1:0]      lsu2wb_ld_data_i,
  output logic                 wb2exe_stall_o,
  output logic                 wb2idu_wr_req_o,
  output logic [RF_AWIDTH-1:0] wb2idu_rd_addr_o,
  output logic [XLEN-1:0]      wb2idu_rd_data_o,
  output wb_state_e            dbg_state_o
);

  // Handshake: execute presents an instruction with exe2wb_valid_i; it is taken on any
  // rising edge where valid is high and stall is low, otherwise execute holds it unchanged.

  wb_state_e state_q, state_d;

  logic                 accept;
  logic                 is_load;
  logic                 ld_done;
  logic                 wr_en_new;
  logic [XLEN-1:0]      result_sel;
  logic [XLEN-1:0]      ld_fmt_data;

  logic                 cap_wr_req_q;
  logic [RF_AWIDTH-1:0] cap_rd_addr_q;
  logic [2:0]           cap_ld_ops_q;
  logic [1:0]           cap_off_q;

  logic                 wr_req_q;
  logic [RF_AWIDTH-1:0] rd_addr_q;
  logic [XLEN-1:0]      rd_data_q;

  assign wb2exe_stall_o = (state_q == WB_LD_WAIT);
  assign accept         = exe2wb_valid_i & ~wb2exe_stall_o;
  assign is_load        = (exe2wb_wb_sel_i == WB_LOAD);
  // Flush beats a coincident load response.
  assign ld_done        = (state_q == WB_LD_WAIT) & lsu2wb_ld_valid_i & ~exe2wb_flush_i;
  assign wr_en_new      = exe2wb_rd_wr_req_i & (exe2wb_rd_addr_i != '0);

  always_comb begin
    result_sel = exe2wb_alu_result_i;
    case (exe2wb_wb_sel_i)
      WB_PC4:  result_sel = exe2wb_pc_i + XLEN'(4);
      WB_CSR:  result_sel = exe2wb_csr_rdata_i;
      default: result_sel = exe2wb_alu_result_i;
    endcase
  end

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .ld_ops   (cap_ld_ops_q),
    .offset   (cap_off_q),
    .raw_data (lsu2wb_ld_data_i),
    .ld_data  (ld_fmt_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (accept && is_load) state_d = WB_LD_WAIT;
      end
      WB_LD_WAIT: begin
        if (exe2wb_flush_i || lsu2wb_ld_valid_i) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_wr_req_q  <= 1'b0;
      cap_rd_addr_q <= '0;
      cap_ld_ops_q  <= 3'd0;
      cap_off_q     <= 2'd0;
    end else if (accept && is_load) begin
      cap_wr_req_q  <= wr_en_new;
      cap_rd_addr_q <= exe2wb_rd_addr_i;
      cap_ld_ops_q  <= exe2wb_ld_ops_i;
      cap_off_q     <= exe2wb_alu_result_i[1:0];
    end
  end

  // Address and data follow every completed instruction; only the enable is gated by x0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_req_q <= 1'b0;
      if (ld_done) begin
        wr_req_q  <= cap_wr_req_q;
        rd_addr_q <= cap_rd_addr_q;
        rd_data_q <= ld_fmt_data;
      end else if (accept && !is_load) begin
        wr_req_q  <= wr_en_new;
        rd_addr_q <= exe2wb_rd_addr_i;
        rd_data_q <= result_sel;
      end
    end
  end

  assign wb2idu_wr_req_o  = wr_req_q;
  assign wb2idu_rd_addr_o = rd_addr_q;
  assign wb2idu_rd_data_o = rd_data_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic,
// with every register-file write checked against an expected queue.
module tb_writeback_unit;
  import pcore_types_pkg::*;

  localparam int W = 37;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        rd_wr_req;
  logic [4:0]  rd_addr;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic [2:0]  ld_ops;
  logic        flush;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        stall;
  logic        wr_req;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  wb_state_e   dbg_state;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  logic       pend_wr;
  logic [4:0] pend_rd;
  logic [2:0] pend_ops;
  logic [1:0] pend_off;

  writeback_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .exe2wb_valid_i      (valid),
    .exe2wb_rd_wr_req_i  (rd_wr_req),
    .exe2wb_rd_addr_i    (rd_addr),
    .exe2wb_wb_sel_i     (wb_sel),
    .exe2wb_alu_result_i (alu_result),
    .exe2wb_pc_i         (pc),
    .exe2wb_csr_rdata_i  (csr_rdata),
    .exe2wb_ld_ops_i     (ld_ops),
    .exe2wb_flush_i      (flush),
    .lsu2wb_ld_valid_i   (ld_valid),
    .lsu2wb_ld_data_i    (ld_data),
    .wb2exe_stall_o      (stall),
    .wb2idu_wr_req_o     (wr_req),
    .wb2idu_rd_addr_o    (wr_addr),
    .wb2idu_rd_data_o    (wr_data),
    .dbg_state_o         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] ops, input logic [1:0] off,
                                      input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> (32'(off) * 8);
    case (ops)
      3'd0: return {{24{sh[7]}}, sh[7:0]};
      3'd4: return {24'h0, sh[7:0]};
      3'd1: begin sh = raw >> (off[1] ? 16 : 0); return {{16{sh[15]}}, sh[15:0]}; end
      3'd5: begin sh = raw >> (off[1] ? 16 : 0); return {16'h0, sh[15:0]}; end
      default: return raw;
    endcase
  endfunction

  // scoreboard: every write the DUT makes must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && wr_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'h0, wr_addr, wr_data}, 64'h0);
      end else begin
        check("wb_write", {27'h0, wr_addr, wr_data}, {27'h0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic wr,
                      input logic [31:0] alu, input logic [31:0] pcv,
                      input logic [31:0] csr, input logic [2:0] ops);
    logic accepted;
    logic [31:0] res;
    int n;
    valid = 1'b1; wb_sel = sel; rd_addr = rd; rd_wr_req = wr;
    alu_result = alu; pc = pcv; csr_rdata = csr; ld_ops = ops;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      accepted = !stall;
      tick();
      n++;
    end
    valid = 1'b0;
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    if (sel == WB_LOAD) begin
      pend_wr = wr; pend_rd = rd; pend_ops = ops; pend_off = alu[1:0];
    end else if (wr && rd != 5'd0) begin
      res = (sel == WB_PC4) ? pcv + 32'd4 : (sel == WB_CSR) ? csr : alu;
      exp_q.push_back({rd, res});
    end
  endtask

  task automatic lsu_respond(input logic [31:0] raw, input int delay);
    for (int i = 1; i < delay; i++) begin
      check("ld_wait_stall", 64'(stall), 64'd1);
      tick();
    end
    check("ld_valid_stall", 64'(stall), 64'd1);
    ld_valid = 1'b1;
    ld_data = raw;
    if (pend_wr && pend_rd != 5'd0) exp_q.push_back({pend_rd, fmt(pend_ops, pend_off, raw)});
    tick();
    ld_valid = 1'b0;
    check("ld_done_stall", 64'(stall), 64'd0);
    check("ld_done_wr_req", 64'(wr_req), 64'(pend_wr && pend_rd != 5'd0));
  endtask

  initial begin
    checks = 0; failures = 0;
    valid = 0; rd_wr_req = 0; rd_addr = 0; wb_sel = 0; alu_result = 0; pc = 0;
    csr_rdata = 0; ld_ops = 0; flush = 0; ld_valid = 0; ld_data = 0;
    pend_wr = 0; pend_rd = 0; pend_ops = 0; pend_off = 0;
    rst_n = 0;
    repeat (3) tick();
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(WB_IDLE));
    rst_n = 1;
    tick();

    // ALU write lasts exactly one cycle
    send(WB_ALU, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 3'd0);
    check("alu_wr_req", 64'(wr_req), 64'd1);
    check("alu_addr", 64'(wr_addr), 64'd5);
    check("alu_data", 64'(wr_data), 64'h1234_5678);
    check("alu_stall", 64'(stall), 64'd0);
    tick();
    check("alu_one_cycle", 64'(wr_req), 64'd0);

    // LB sign extend, response 4 cycles after accept
    send(WB_LOAD, 5'd7, 1'b1, 32'h0000_1003, 32'h0, 32'h0, 3'd0);
    check("lb_stall_after_accept", 64'(stall), 64'd1);
    lsu_respond(32'h80FF_7F01, 4);
    check("lb_addr", 64'(wr_addr), 64'd7);
    check("lb_data", 64'(wr_data), 64'hFFFF_FF80);
    tick();

    send(WB_LOAD, 5'd8, 1'b1, 32'h0000_0002, 32'h0, 32'h0, 3'd5);
    lsu_respond(32'h80FF_7F01, 2);
    check("lhu_data", 64'(wr_data), 64'h0000_80FF);
    send(WB_LOAD, 5'd9, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 3'd4);
    lsu_respond(32'h80FF_7F01, 1);
    check("lbu_data", 64'(wr_data), 64'h0000_007F);

    // PC+4 wrap and x0 / no-write suppression
    send(WB_PC4, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0);
    check("pc4_wr_req", 64'(wr_req), 64'd1);
    check("pc4_data", 64'(wr_data), 64'h0);
    send(WB_ALU, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0);
    check("x0_wr_req", 64'(wr_req), 64'd0);
    send(WB_CSR, 5'd3, 1'b0, 32'h0, 32'h0, 32'hCAFE_0003, 3'd0);
    check("nowr_wr_req", 64'(wr_req), 64'd0);
    check("nowr_addr_update", 64'(wr_addr), 64'd3);
    check("nowr_data_update", 64'(wr_data), 64'hCAFE_0003);

    // ld_valid and flush while idle are ignored
    ld_valid = 1; ld_data = 32'h5555_5555; flush = 1;
    tick();
    ld_valid = 0; flush = 0;
    check("idle_ld_valid_wr", 64'(wr_req), 64'd0);
    check("idle_ld_valid_state", 64'(dbg_state), 64'(WB_IDLE));

    // flush coincident with ld_valid
    send(WB_LOAD, 5'd4, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2);
    tick();
    flush = 1; ld_valid = 1; ld_data = 32'h1111_2222;
    tick();
    flush = 0; ld_valid = 0;
    check("flush_wr_req", 64'(wr_req), 64'd0);
    check("flush_stall", 64'(stall), 64'd0);
    check("flush_state", 64'(dbg_state), 64'(WB_IDLE));
    send(WB_ALU, 5'd6, 1'b1, 32'h0000_00A6, 32'h0, 32'h0, 3'd0);
    check("post_flush_wr", 64'(wr_req), 64'd1);

    // back-to-back: ALU held behind a pending load
    send(WB_LOAD, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2);
    valid = 1; wb_sel = WB_ALU; rd_addr = 5'd11; rd_wr_req = 1; alu_result = 32'h0BAD_F00D;
    tick();
    check("b2b_held_stall", 64'(stall), 64'd1);
    check("b2b_held_wr", 64'(wr_req), 64'd0);
    ld_valid = 1; ld_data = 32'h7777_8888;
    exp_q.push_back({5'd10, 32'h7777_8888});
    exp_q.push_back({5'd11, 32'h0BAD_F00D});
    tick();
    ld_valid = 0;
    check("b2b_load_addr", 64'(wr_addr), 64'd10);
    check("b2b_load_wr", 64'(wr_req), 64'd1);
    check("b2b_stall_low", 64'(stall), 64'd0);
    tick();
    valid = 0;
    check("b2b_alu_addr", 64'(wr_addr), 64'd11);
    check("b2b_alu_wr", 64'(wr_req), 64'd1);
    tick();

    // reset while a load is pending
    send(WB_LOAD, 5'd12, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2);
    tick();
    rst_n = 0;
    tick();
    check("rst_ld_wr_req", 64'(wr_req), 64'd0);
    check("rst_ld_data", 64'(wr_data), 64'd0);
    check("rst_ld_addr", 64'(wr_addr), 64'd0);
    check("rst_ld_stall", 64'(stall), 64'd0);
    rst_n = 1;
    tick();
    ld_valid = 1; ld_data = 32'h9999_9999;
    tick();
    ld_valid = 0;
    check("rst_ld_ignored", 64'(wr_req), 64'd0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      send(sel, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, $urandom(),
           $urandom(), $urandom(), 3'($urandom_range(0, 7)));
      if (sel == WB_LOAD) lsu_respond($urandom(), $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
